spi_slave_param: RTL

Parametrised successor to the team's fixed 10-bit SPI slave. It receives frames of 2 command bits plus DATA_W payload bits on MOSI, sampling on clk, and presents each completed frame on rx_data with a one-cycle rx_valid pulse. For read-data frames it waits for tx_valid, then shifts tx_data out on MISO MSB-first. New relative to the previous generation: payload width is configurable, frames truncated by SS_n are detected and reported, and clean DONE/WAIT_TX phases are added.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_tx_shifter.sv | 30 +++
 rtl/spi_slave_param.sv | 115 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and command constants for the parametrised SPI slave.
package spi_pkg;
    localparam int CMD_W = 2;
    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND,
        DONE
    } spi_state_e;
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: holds the read data and presents it MSB-first, flagging the last bit.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift_en,
    output logic              o_bit,
    output logic              o_done
);
    localparam int CW = $clog2(DATA_W + 1);
    logic [DATA_W-1:0] r_sh;
    logic [CW-1:0]     r_cnt;
    assign o_bit  = r_sh[DATA_W-1];
    assign o_done = r_cnt == CW'(DATA_W - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_data;
            r_cnt <= '0;
        end else if (i_shift_en) begin
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave receiving {cmd, payload} frames and returning read data on MISO,
// with truncated-frame detection when SS_n rises mid-frame.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 3)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SS_n,
    input  logic                    MOSI,
    input  logic                    tx_valid,
    input  logic [DATA_W-1:0]       tx_data,
    output logic                    MISO,
    output logic [DATA_W+CMD_W-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    frame_err,
    output logic                    rd_pending,
    output logic                    busy
);
    localparam int FRAME_W = DATA_W + CMD_W;
    spi_state_e         r_state, w_next;
    logic [FRAME_W-1:0] r_rx_sh;
    logic [FRAME_W-1:0] w_frame;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_miso, r_rx_valid, r_frame_err, r_rd_pending;
    logic [FRAME_W-1:0] r_rx_data;
    logic               w_abort, w_frame_done, w_shifting, w_load, w_shift_en;
    logic               w_tx_bit, w_tx_done;
    assign w_frame    = {r_rx_sh[FRAME_W-2:0], MOSI};
    assign MISO       = r_miso;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign rd_pending = r_rd_pending;
    assign busy       = r_state != IDLE;
    always_comb begin
        w_next       = r_state;
        w_abort      = 1'b0;
        w_frame_done = 1'b0;
        w_shifting   = 1'b0;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            IDLE: w_next = SS_n ? IDLE : CHK_CMD;
            CHK_CMD: begin
                w_abort = SS_n;
                w_next  = SS_n ? IDLE : !MOSI ? WRITE : r_rd_pending ? READ_DATA : READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                w_abort      = SS_n;
                w_shifting   = !SS_n;
                w_frame_done = !SS_n && r_bit_cnt == CNT_W'(FRAME_W - 1);
                if (SS_n)
                    w_next = IDLE;
                else if (w_frame_done)
                    w_next = (r_state == READ_DATA) ? WAIT_TX : DONE;
            end
            WAIT_TX: begin
                w_abort = SS_n;
                w_load  = !SS_n && tx_valid;
                w_next  = SS_n ? IDLE : tx_valid ? SEND : WAIT_TX;
            end
            SEND: begin
                w_abort    = SS_n;
                w_shift_en = !SS_n;
                w_next     = SS_n ? IDLE : w_tx_done ? DONE : SEND;
            end
            DONE: w_next = SS_n ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rx_sh      <= '0;
            r_bit_cnt    <= '0;
            r_miso       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rx_data    <= '0;
        end else begin
            r_state     <= w_next;
            r_rx_valid  <= w_frame_done;
            r_frame_err <= w_abort;
            r_miso      <= w_shift_en ? w_tx_bit : 1'b0;
            if (r_state == CHK_CMD && !SS_n) begin
                r_rx_sh   <= {{(FRAME_W-1){1'b0}}, MOSI};
                r_bit_cnt <= CNT_W'(1);
            end else if (w_shifting) begin
                r_rx_sh   <= w_frame;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            // cmd[0] rides along in the frame; only the state decides rd_pending
            if (w_frame_done) begin
                r_rx_data <= w_frame;
                if (r_state == READ_ADD)
                    r_rd_pending <= 1'b1;
                else if (r_state == READ_DATA)
                    r_rd_pending <= 1'b0;
            end
        end
    end
    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_data    (tx_data),
        .i_shift_en(w_shift_en),
        .o_bit     (w_tx_bit),
        .o_done    (w_tx_done)
    );
endmodule
